// File: rtl/mips_multicycle_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : mips_multicycle_ctrl
//  Purpose  : Multicycle MIPS control FSM with mem_ready stretching, memory
//             timeout fault, illegal-opcode flag and retired-instruction count.
//  Revision : 1.0
// ============================================================================
module mips_multicycle_ctrl #(
    parameter int unsigned MEM_WAIT_MAX = 15,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             initiate,
    input  logic [5:0]       opcode,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             pc_write_cond,
    output logic             iord,
    output logic             mem_read,
    output logic             mem_write,
    output logic             ir_write,
    output logic             mem_to_reg,
    output logic             reg_dst,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       pc_source,
    output logic [3:0]       state,
    output logic             illegal_op,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] instr_retired
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,  S_ADDIEX = 4'd9,  S_ADDIWB = 4'd10, S_JUMP   = 4'd11,
        S_FAULT  = 4'd12
    } state_t;

    localparam logic [5:0] C_OP_R    = 6'b000000;
    localparam logic [5:0] C_OP_J    = 6'b000010;
    localparam logic [5:0] C_OP_BEQ  = 6'b000100;
    localparam logic [5:0] C_OP_ADDI = 6'b001000;
    localparam logic [5:0] C_OP_LW   = 6'b100011;
    localparam logic [5:0] C_OP_SW   = 6'b101011;
    localparam logic [7:0] C_WAIT_LIMIT = 8'(MEM_WAIT_MAX);

    state_t           state_q,   state_d;
    logic [7:0]       wait_q,    wait_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic             illegal_q, illegal_d;
    logic             timeout_q, timeout_d;
    logic             is_sw_q,   is_sw_d;
    logic             w_wait_hit;
    logic             w_stall_state;
    logic             w_retire;

    assign w_wait_hit    = (MEM_WAIT_MAX != 0) && (wait_q == C_WAIT_LIMIT);
    assign w_stall_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        is_sw_d   = is_sw_q;
        w_retire  = 1'b0;
        case (state_q)
            S_FETCH: begin
                if (mem_ready)       state_d = S_DECODE;
                else if (w_wait_hit) state_d = S_FAULT;
            end
            S_DECODE: begin
                // lw/sw share MEMADR, so remember which one it was
                is_sw_d = (opcode == C_OP_SW);
                case (opcode)
                    C_OP_LW, C_OP_SW: state_d = S_MEMADR;
                    C_OP_R:           state_d = S_EXEC;
                    C_OP_BEQ:         state_d = S_BRANCH;
                    C_OP_ADDI:        state_d = S_ADDIEX;
                    C_OP_J:           state_d = S_JUMP;
                    default: begin
                        state_d   = S_FETCH;
                        illegal_d = 1'b1;
                    end
                endcase
            end
            S_MEMADR: state_d = is_sw_q ? S_MEMWR : S_MEMRD;
            S_MEMRD: begin
                if (mem_ready)       state_d = S_MEMWB;
                else if (w_wait_hit) state_d = S_FAULT;
            end
            S_MEMWR: begin
                if (mem_ready) begin
                    state_d  = S_FETCH;
                    w_retire = 1'b1;
                end else if (w_wait_hit) begin
                    state_d = S_FAULT;
                end
            end
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            S_MEMWB, S_ALUWB, S_BRANCH, S_ADDIWB, S_JUMP: begin
                state_d  = S_FETCH;
                w_retire = 1'b1;
            end
            S_FAULT:  state_d = S_FAULT;
            default:  state_d = S_FAULT;
        endcase

        if (state_d != state_q)              wait_d = 8'd0;
        else if (w_stall_state && !mem_ready) wait_d = wait_q + 8'd1;
        else                                  wait_d = wait_q;

        cnt_d     = w_retire ? cnt_q + CNT_W'(1) : cnt_q;
        timeout_d = timeout_q | (state_d == S_FAULT);
    end

    always_ff @(posedge clk or negedge initiate) begin
        if (!initiate) begin
            state_q   <= S_FETCH;
            wait_q    <= 8'd0;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            is_sw_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
            is_sw_q   <= is_sw_d;
        end
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        case (state_q)
            S_FETCH: begin
                // reset holds FETCH, but must not load PC/IR while held
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready & initiate;
                pc_write  = mem_ready & initiate;
            end
            S_DECODE: alu_src_b = 2'b11;
            S_MEMADR, S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
            end
            S_ADDIWB: reg_write = 1'b1;
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
            default: ;
        endcase
    end

    assign state         = state_q;
    assign illegal_op    = illegal_q;
    assign mem_timeout   = timeout_q;
    assign instr_retired = cnt_q;

endmodule
`default_nettype wire
